// File: rtl/ddi_phase_scheduler_if.sv
// Handshake bundle between the timebase/sensor side and the DDI phase scheduler.
// The master drives time-base, maintenance and demand inputs; the slave is the scheduler.
interface ddi_phase_scheduler_if;
  logic       tick;
  logic       maintenance;
  logic       east_req;
  logic       west_req;
  logic       timing_done;
  logic [1:0] phase;
  logic [1:0] stage;
  logic       east_pend;
  logic       west_pend;

  modport master (
    output tick, maintenance, east_req, west_req,
    input  timing_done, phase, stage, east_pend, west_pend
  );

  modport slave (
    input  tick, maintenance, east_req, west_req,
    output timing_done, phase, stage, east_pend, west_pend
  );
endinterface

// File: rtl/ddi_phase_scheduler.sv
// Stage timer, advance strobe and next-phase arbiter that feeds one interchange's DDI
// signal FSM; alternates normal phases with at most one latched priority phase between them.
module ddi_phase_scheduler #(
  parameter int GREEN_TICKS   = 30,
  parameter int YELLOW_TICKS  = 4,
  parameter int ALL_RED_TICKS = 2,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ddi_phase_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_MAINT  = 2'd3
  } stage_e;

  localparam logic [1:0]       PH_EAST     = 2'b10;
  localparam logic [1:0]       PH_WEST     = 2'b11;
  localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(ALL_RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  stage_e           stage_q, stage_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             done_q, done_d;
  logic [1:0]       phase_q, phase_d;
  logic             next_norm_q, next_norm_d;   // low bit of the next normal phase
  logic             prio_ptr_q, prio_ptr_d;     // 0 = east served next on a tie
  logic             last_prio_q, last_prio_d;
  logic             east_pend_q, east_pend_d;
  logic             west_pend_q, west_pend_d;

  logic expire;
  logic arb;
  logic east_eff, west_eff;
  logic sel_norm, sel_east, sel_west, tie;

  assign expire   = (stage_q != ST_MAINT) && bus.tick && (timer_q == '0);
  assign arb      = !bus.maintenance && (stage_q == ST_RED) && expire;
  // A request arriving in the arbitration cycle itself is already eligible.
  assign east_eff = east_pend_q | bus.east_req;
  assign west_eff = west_pend_q | bus.west_req;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= ST_RED;
    else     stage_q <= stage_d;
  end

  // Next-state logic; maintenance overrides any same-cycle expiry.
  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    stage_d = stage_q;
    if (bus.maintenance) begin
      stage_d = ST_MAINT;
    end else begin
      unique case (stage_q)
        ST_RED:    if (expire) stage_d = ST_GREEN;
        ST_GREEN:  if (expire) stage_d = ST_YELLOW;
        ST_YELLOW: if (expire) stage_d = ST_RED;
        ST_MAINT:  stage_d = ST_RED;
        default:   stage_d = ST_RED;
      endcase
    end
  end

  // Output/datapath logic: timer, strobe and arbitration.
  always_comb begin
    timer_d     = timer_q;
    done_d      = 1'b0;
    phase_d     = phase_q;
    next_norm_d = next_norm_q;
    prio_ptr_d  = prio_ptr_q;
    last_prio_d = last_prio_q;
    sel_norm    = 1'b0;
    sel_east    = 1'b0;
    sel_west    = 1'b0;
    tie         = 1'b0;

    if (!bus.maintenance) begin
      if (stage_q == ST_MAINT) begin
        timer_d = RED_LOAD;
        done_d  = 1'b1;
      end else if (expire) begin
        done_d = 1'b1;
        unique case (stage_q)
          ST_RED:   timer_d = GREEN_LOAD;
          ST_GREEN: timer_d = YELLOW_LOAD;
          default:  timer_d = RED_LOAD;
        endcase
      end else if (bus.tick) begin
        timer_d = timer_q - CNT_ONE;
      end
    end

    // Forcing a normal phase after a priority phase bounds starvation of the rotation.
    if (last_prio_q) begin
      sel_norm = 1'b1;
    end else if (east_eff && west_eff) begin
      tie      = 1'b1;
      sel_east = !prio_ptr_q;
      sel_west = prio_ptr_q;
    end else if (east_eff) begin
      sel_east = 1'b1;
    end else if (west_eff) begin
      sel_west = 1'b1;
    end else begin
      sel_norm = 1'b1;
    end

    if (arb) begin
      last_prio_d = !sel_norm;
      if (tie) prio_ptr_d = !prio_ptr_q;
      if (sel_norm) begin
        phase_d     = {1'b0, next_norm_q};
        next_norm_d = !next_norm_q;
      end else if (sel_east) begin
        phase_d = PH_EAST;
      end else begin
        phase_d = PH_WEST;
      end
    end

    east_pend_d = east_eff && !(arb && sel_east);
    west_pend_d = west_eff && !(arb && sel_west);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q     <= RED_LOAD;
      done_q      <= 1'b0;
      phase_q     <= 2'b00;
      next_norm_q <= 1'b0;
      prio_ptr_q  <= 1'b0;
      last_prio_q <= 1'b0;
      east_pend_q <= 1'b0;
      west_pend_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      done_q      <= done_d;
      phase_q     <= phase_d;
      next_norm_q <= next_norm_d;
      prio_ptr_q  <= prio_ptr_d;
      last_prio_q <= last_prio_d;
      east_pend_q <= east_pend_d;
      west_pend_q <= west_pend_d;
    end
  end

  assign bus.timing_done = done_q;
  assign bus.phase       = phase_q;
  assign bus.stage       = stage_q;
  assign bus.east_pend   = east_pend_q;
  assign bus.west_pend   = west_pend_q;

endmodule

// File: tb/tb_ddi_phase_scheduler.sv
// Directed bench for ddi_phase_scheduler: expected phase/stage per strobe are queued as
// each step is driven and compared, with strobe spacing, whenever timing_done fires.
module tb_ddi_phase_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddi_phase_scheduler_if bus();

  ddi_phase_scheduler #(
    .GREEN_TICKS(30), .YELLOW_TICKS(4), .ALL_RED_TICKS(2), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0] phase;
    logic [1:0] stage;
  } exp_t;

  localparam logic [1:0] S_RED = 2'd0, S_GREEN = 2'd1, S_YELLOW = 2'd2, S_MAINT = 2'd3;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cycles   = 0;
  int   last_strobe = 0;
  int   tick_div = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock step; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    cycles++;
    bus.tick = (tick_div <= 1) || ((cycles % tick_div) == 0);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.maintenance = 1'b0;
    bus.east_req    = 1'b0;
    bus.west_req    = 1'b0;
    bus.tick        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst         = 1'b0;
    cycles      = 0;
    last_strobe = 0;
    bus.tick    = 1'b1;
  endtask

  task automatic expect_strobe(input logic [1:0] ph, input logic [1:0] st);
    sb.push_back({ph, st});
  endtask

  // Waits (bounded) for the next strobe and compares it with the scoreboard head.
  task automatic wait_strobe(input int gap, input string tag);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (bus.timing_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " strobe seen"}, 32'(seen), 32'd1);
    if (seen) begin
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      check({tag, " phase"}, 32'(bus.phase), 32'(e.phase));
      check({tag, " stage"}, 32'(bus.stage), 32'(e.stage));
      if (gap >= 0) check({tag, " gap"}, 32'(cycles - last_strobe), 32'(gap));
      last_strobe = cycles;
    end
  endtask

  task automatic full_cycle(input logic [1:0] ph, input string tag);
    expect_strobe(ph, S_GREEN);
    wait_strobe(2, {tag, " red"});
    expect_strobe(ph, S_YELLOW);
    wait_strobe(30, {tag, " green"});
    expect_strobe(ph, S_RED);
    wait_strobe(4, {tag, " yellow"});
  endtask

  initial begin
    // Reset values and plain rotation.
    do_reset();
    check("rst stage", 32'(bus.stage), 32'(S_RED));
    check("rst phase", 32'(bus.phase), 32'd0);
    check("rst done", 32'(bus.timing_done), 32'd0);
    check("rst east_pend", 32'(bus.east_pend), 32'd0);
    check("rst west_pend", 32'(bus.west_pend), 32'd0);
    full_cycle(2'b00, "rot0");
    full_cycle(2'b01, "rot1");
    full_cycle(2'b00, "rot2");
    full_cycle(2'b01, "rot3");

    // East pulse during PHASE_1 green.
    do_reset();
    expect_strobe(2'b00, S_GREEN);
    wait_strobe(2, "ep red");
    repeat (3) step();
    bus.east_req = 1'b1;
    step();
    bus.east_req = 1'b0;
    check("ep east_pend set", 32'(bus.east_pend), 32'd1);
    expect_strobe(2'b00, S_YELLOW);
    wait_strobe(30, "ep green");
    expect_strobe(2'b00, S_RED);
    wait_strobe(4, "ep yellow");
    expect_strobe(2'b10, S_GREEN);
    wait_strobe(2, "ep arb east");
    check("ep east_pend clr", 32'(bus.east_pend), 32'd0);
    expect_strobe(2'b10, S_YELLOW);
    wait_strobe(30, "ep green2");
    expect_strobe(2'b10, S_RED);
    wait_strobe(4, "ep yellow2");
    expect_strobe(2'b01, S_GREEN);
    wait_strobe(2, "ep forced normal");

    // Both demands held from reset.
    do_reset();
    bus.east_req = 1'b1;
    bus.west_req = 1'b1;
    full_cycle(2'b10, "both0");
    full_cycle(2'b00, "both1");
    full_cycle(2'b11, "both2");
    full_cycle(2'b01, "both3");
    full_cycle(2'b10, "both4");
    bus.east_req = 1'b0;
    bus.west_req = 1'b0;

    // Maintenance mid-GREEN with a west pulse latched while frozen.
    do_reset();
    expect_strobe(2'b00, S_GREEN);
    wait_strobe(2, "mt red");
    repeat (5) step();
    bus.maintenance = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("mt stage", 32'(bus.stage), 32'(S_MAINT));
      check("mt no strobe", 32'(bus.timing_done), 32'd0);
      bus.west_req = (i == 3);
    end
    bus.west_req = 1'b0;
    check("mt west_pend kept", 32'(bus.west_pend), 32'd1);
    bus.maintenance = 1'b0;
    expect_strobe(2'b00, S_RED);
    wait_strobe(16, "mt release");
    expect_strobe(2'b11, S_GREEN);
    wait_strobe(2, "mt arb west");
    check("mt west_pend clr", 32'(bus.west_pend), 32'd0);

    // Maintenance in the exact YELLOW expiry cycle.
    do_reset();
    expect_strobe(2'b00, S_GREEN);
    wait_strobe(2, "my red");
    expect_strobe(2'b00, S_YELLOW);
    wait_strobe(30, "my green");
    repeat (3) step();
    bus.maintenance = 1'b1;
    step();
    check("my no strobe", 32'(bus.timing_done), 32'd0);
    check("my stage", 32'(bus.stage), 32'(S_MAINT));
    bus.maintenance = 1'b0;
    expect_strobe(2'b00, S_RED);
    wait_strobe(5, "my release");
    expect_strobe(2'b01, S_GREEN);
    wait_strobe(2, "my arb");

    // Tick every 4th cycle stretches stage lengths fourfold.
    tick_div = 4;
    do_reset();
    expect_strobe(2'b00, S_GREEN);
    wait_strobe(-1, "slow red");
    expect_strobe(2'b00, S_YELLOW);
    wait_strobe(120, "slow green");
    expect_strobe(2'b00, S_RED);
    wait_strobe(16, "slow yellow");
    tick_div = 1;

    // Reset asserted mid-YELLOW.
    do_reset();
    bus.east_req = 1'b1;
    expect_strobe(2'b10, S_GREEN);
    wait_strobe(2, "rm red");
    expect_strobe(2'b10, S_YELLOW);
    wait_strobe(30, "rm green");
    step();
    step();
    check("rm east_pend pre", 32'(bus.east_pend), 32'd1);
    rst          = 1'b1;
    bus.east_req = 1'b0;
    #1;
    check("rm stage", 32'(bus.stage), 32'(S_RED));
    check("rm phase", 32'(bus.phase), 32'd0);
    check("rm done", 32'(bus.timing_done), 32'd0);
    check("rm east_pend", 32'(bus.east_pend), 32'd0);
    check("rm west_pend", 32'(bus.west_pend), 32'd0);
    do_reset();
    expect_strobe(2'b00, S_GREEN);
    wait_strobe(2, "rm after");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
